// File: rtl/cell_call_ret_sync_pkg.sv
// Shared types and default parameter values for the cell call/return synchroniser.
// The state encoding is common to the top and to any bench that wants to decode it.
package cell_call_ret_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_NUM_CTRL       = 1;
  localparam int DEF_CALL_DELAY     = 1;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_HAS_DOWNSTREAM = 1;

endpackage

// File: rtl/cell_call_ret_sync_if.sv
// Call/return bundle of one cell: upstream call, downstream ret, local controllers, status.
// slave is the cell side; master is whoever drives the cell (neighbouring logic or a bench).
interface cell_call_ret_sync_if
  import cell_call_ret_sync_pkg::*;
#(
  parameter int NUM_CTRL  = DEF_NUM_CTRL,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

  logic                 call_in;
  logic                 call_out;
  logic                 ret_in;
  logic                 ret_out;
  logic [NUM_CTRL-1:0]  ctrl_mask;
  logic [NUM_CTRL-1:0]  ctrl_call;
  logic [NUM_CTRL-1:0]  ctrl_ret;
  logic                 busy;
  logic [CNT_WIDTH-1:0] run_cycles;
  logic                 err;

  modport slave (
    input  call_in, ret_in, ctrl_mask, ctrl_ret,
    output call_out, ret_out, ctrl_call, busy, run_cycles, err
  );

  modport master (
    output call_in, ret_in, ctrl_mask, ctrl_ret,
    input  call_out, ret_out, ctrl_call, busy, run_cycles, err
  );

endinterface

// File: rtl/call_delay_line.sv
// Single-bit shift register of DEPTH stages with synchronous reset.
// Output is the input delayed by exactly DEPTH clocks; DEPTH must be at least 1.
module call_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (rst) sr_q <= 1'b0;
        else     sr_q <= d_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (rst) sr_q <= '0;
        else     sr_q <= {sr_q[DEPTH-2:0], d_i};
      end
    end
  endgenerate

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/cell_call_ret_sync.sv
// Call/return synchroniser for one chain cell: fans a call out to local sequencers,
// forwards it downstream, and raises ret_out once every unmasked party has returned.
//
// state | meaning
// IDLE  | no call seen since reset
// RUN   | call accepted, waiting for controller/downstream returns
// DONE  | all returns collected, ret_out held high until the next call
module cell_call_ret_sync
  import cell_call_ret_sync_pkg::*;
#(
  parameter int NUM_CTRL       = DEF_NUM_CTRL,
  parameter int CALL_DELAY     = DEF_CALL_DELAY,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int HAS_DOWNSTREAM = DEF_HAS_DOWNSTREAM
) (
  input logic                 clk,
  input logic                 rst,
  cell_call_ret_sync_if.slave bus
);

  localparam bit                 DS_EN   = (HAS_DOWNSTREAM != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_e               state_q;
  logic [NUM_CTRL-1:0]  done_q, done_d;
  logic                 ds_q, ds_d;
  logic [NUM_CTRL-1:0]  ctrl_call_q;
  logic                 busy_q;
  logic                 ret_out_q;
  logic [CNT_WIDTH-1:0] run_cycles_q;
  logic                 err_q, err_d;

  logic in_run;
  logic accept;
  logic ret_ds;
  logic complete;

  assign in_run = (state_q == ST_RUN);
  assign accept = bus.call_in & ~in_run;
  assign ret_ds = bus.ret_in & DS_EN;

  // A return on a flag that is already set covers masked controllers too,
  // since their flags are preset at acceptance.
  always_comb begin
    done_d   = done_q | bus.ctrl_ret;
    ds_d     = ds_q | ret_ds;
    complete = (&done_d) & ds_d;
    err_d    = 1'b0;
    if (in_run)
      err_d = bus.call_in | (|(bus.ctrl_ret & done_q)) | (ret_ds & ds_q);
    else
      err_d = (|bus.ctrl_ret) | ret_ds;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      done_q       <= '0;
      ds_q         <= 1'b0;
      ctrl_call_q  <= '0;
      busy_q       <= 1'b0;
      ret_out_q    <= 1'b0;
      run_cycles_q <= '0;
      err_q        <= 1'b0;
    end else begin
      ctrl_call_q <= '0;
      err_q       <= err_d;
      case (state_q)
        ST_RUN: begin
          done_q <= done_d;
          ds_q   <= ds_d;
          if (run_cycles_q != CNT_MAX)
            run_cycles_q <= run_cycles_q + CNT_WIDTH'(1);
          if (complete) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            ret_out_q <= 1'b1;
          end
        end
        default: begin
          if (accept) begin
            state_q      <= ST_RUN;
            busy_q       <= 1'b1;
            ret_out_q    <= 1'b0;
            ctrl_call_q  <= ~bus.ctrl_mask;
            done_q       <= bus.ctrl_mask;
            ds_q         <= ~DS_EN;
            run_cycles_q <= '0;
          end
        end
      endcase
    end
  end

  // The delay line is independent of the FSM so calls in flight still emerge.
  call_delay_line #(
    .DEPTH (CALL_DELAY)
  ) u_call_delay (
    .clk (clk),
    .rst (rst),
    .d_i (accept),
    .q_o (bus.call_out)
  );

  assign bus.ctrl_call  = ctrl_call_q;
  assign bus.busy       = busy_q;
  assign bus.ret_out    = ret_out_q;
  assign bus.run_cycles = run_cycles_q;
  assign bus.err        = err_q;

endmodule
